// File: rtl/imu_burst_reader.sv
// SPI mode-3 burst reader: on each trigger reads NUM_WORDS big-endian 16-bit registers in one
// chip-select window and publishes the whole frame atomically with a one-cycle valid pulse.
module imu_burst_reader #(
    parameter int unsigned NUM_WORDS  = 7,
    parameter logic [7:0]  START_ADDR = 8'h3B,
    parameter int unsigned SCK_HALF   = 25,
    parameter int unsigned CS_GAP     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      trig,
    input  logic                      miso,
    output logic                      sck,
    output logic                      mosi,
    output logic                      ss_n,
    output logic                      busy,
    output logic                      valid,
    output logic                      overrun,
    output logic [NUM_WORDS*16-1:0]   data
);

    localparam int unsigned NumBytes = 1 + 2 * NUM_WORDS;
    localparam int unsigned DataW    = NUM_WORDS * 16;
    localparam int unsigned HalfW    = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam int unsigned GapW     = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int unsigned ByteW    = $clog2(NumBytes);

    localparam logic [HalfW-1:0] LastHalf = HalfW'(SCK_HALF - 1);
    localparam logic [GapW-1:0]  LastGap  = GapW'(CS_GAP - 1);
    localparam logic [ByteW-1:0] LastByte = ByteW'(NumBytes - 1);
    localparam logic [7:0]       CmdByte  = START_ADDR | 8'h80;

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StXfer,
        StCsHold,
        StDone
    } state_t;

    state_t             state_q, state_d;
    logic [HalfW-1:0]   half_q, half_d;
    logic               phase_q, phase_d;  // 0: sck low half, 1: sck high half
    logic [2:0]         bit_q, bit_d;
    logic [ByteW-1:0]   byte_q, byte_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [6:0]         rx_q;
    logic [DataW-1:0]   shadow_q;
    logic [DataW-1:0]   data_q;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               overrun_q;
    logic               sample;
    logic               load_data;
    logic [7:0]         tx_byte;
    logic [ByteW-1:0]   wr_idx;

    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        gap_d     = gap_q;
        sample    = 1'b0;
        load_data = 1'b0;

        unique case (state_q)
            StIdle: begin
                half_d  = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                byte_d  = '0;
                gap_d   = '0;
                if (trig && en) begin
                    state_d = StCsSetup;
                end
            end
            StCsSetup: begin
                if (gap_q == LastGap) begin
                    gap_d   = '0;
                    state_d = StXfer;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StXfer: begin
                if (half_q == LastHalf) begin
                    half_d = '0;
                    if (!phase_q) begin
                        // miso is captured on the edge where sck rises
                        phase_d = 1'b1;
                        sample  = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            if (byte_q == LastByte) begin
                                state_d = StCsHold;
                            end else begin
                                byte_d = byte_q + 1'b1;
                            end
                        end
                    end
                end else begin
                    half_d = half_q + 1'b1;
                end
            end
            StCsHold: begin
                if (gap_q == LastGap) begin
                    gap_d     = '0;
                    load_data = 1'b1;
                    state_d   = StDone;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        tx_byte = (byte_d == '0) ? CmdByte : 8'hFF;
        sck_d   = !(state_d == StXfer && !phase_d);
        mosi_d  = (state_d == StXfer) ? tx_byte[3'd7 - bit_d] : 1'b1;
        // Byte j (j>=1) lands in word (j-1)/2, high half when j-1 is even
        wr_idx  = (byte_q - ByteW'(1)) ^ ByteW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            half_q    <= '0;
            phase_q   <= 1'b0;
            bit_q     <= '0;
            byte_q    <= '0;
            gap_q     <= '0;
            rx_q      <= '0;
            shadow_q  <= '0;
            data_q    <= '0;
            sck_q     <= 1'b1;
            mosi_q    <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            gap_q     <= gap_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            overrun_q <= trig && en && (state_q != StIdle);
            if (sample) begin
                rx_q <= {rx_q[5:0], miso};
                if (bit_q == 3'd7 && byte_q != '0) begin
                    shadow_q[{wr_idx, 3'b000} +: 8] <= {rx_q, miso};
                end
            end
            if (load_data) begin
                data_q <= shadow_q;
            end
        end
    end

    assign busy    = (state_q == StCsSetup) || (state_q == StXfer) || (state_q == StCsHold);
    assign ss_n    = !busy;
    assign valid   = (state_q == StDone);
    assign overrun = overrun_q;
    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign data    = data_q;

endmodule

// File: tb/tb_imu_burst_reader.sv
// Bench for imu_burst_reader: three configurations with SPI slave models; expected frames are
// queued at trigger time and popped by a monitor whenever a DUT raises valid.
module tb_imu_burst_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;
    int ovr0 = 0, ovr1 = 0, ovr2 = 0;

    // dut0: defaults; dut1: 1 word, SCK_HALF=2, CS_GAP=1; dut2: 2 words, SCK_HALF=1, CS_GAP=1
    logic rst0 = 1'b1, en0 = 1'b1, trig0 = 1'b0, miso0 = 1'b1;
    logic rst1 = 1'b1, en1 = 1'b1, trig1 = 1'b0, miso1 = 1'b1;
    logic rst2 = 1'b1, en2 = 1'b1, trig2 = 1'b0, miso2 = 1'b1;
    logic sck0, mosi0, ss_n0, busy0, valid0, overrun0;
    logic sck1, mosi1, ss_n1, busy1, valid1, overrun1;
    logic sck2, mosi2, ss_n2, busy2, valid2, overrun2;
    logic [111:0] data0;
    logic [15:0]  data1;
    logic [31:0]  data2;

    imu_burst_reader dut0 (
        .clk(clk), .rst(rst0), .en(en0), .trig(trig0), .miso(miso0),
        .sck(sck0), .mosi(mosi0), .ss_n(ss_n0), .busy(busy0), .valid(valid0),
        .overrun(overrun0), .data(data0)
    );

    imu_burst_reader #(.NUM_WORDS(1), .SCK_HALF(2), .CS_GAP(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .trig(trig1), .miso(miso1),
        .sck(sck1), .mosi(mosi1), .ss_n(ss_n1), .busy(busy1), .valid(valid1),
        .overrun(overrun1), .data(data1)
    );

    imu_burst_reader #(.NUM_WORDS(2), .SCK_HALF(1), .CS_GAP(1)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .trig(trig2), .miso(miso2),
        .sck(sck2), .mosi(mosi2), .ss_n(ss_n2), .busy(busy2), .valid(valid2),
        .overrun(overrun2), .data(data2)
    );

    // Mode-3 slaves: shift out the next bit on each falling sck edge while selected
    logic [7:0] s0_bytes [15];
    logic [7:0] s1_bytes [3];
    logic [7:0] s2_bytes [5];
    int s0_bit = 0, s1_bit = 0, s2_bit = 0;

    always @(negedge sck0 or posedge ss_n0) begin
        if (ss_n0) s0_bit = 0;
        else if (s0_bit < 120) begin
            miso0 <= s0_bytes[s0_bit / 8][7 - (s0_bit % 8)];
            s0_bit++;
        end
    end

    always @(negedge sck1 or posedge ss_n1) begin
        if (ss_n1) s1_bit = 0;
        else if (s1_bit < 24) begin
            miso1 <= s1_bytes[s1_bit / 8][7 - (s1_bit % 8)];
            s1_bit++;
        end
    end

    always @(negedge sck2 or posedge ss_n2) begin
        if (ss_n2) s2_bit = 0;
        else if (s2_bit < 40) begin
            miso2 <= s2_bytes[s2_bit / 8][7 - (s2_bit % 8)];
            s2_bit++;
        end
    end

    logic [23:0] m1 = '0;
    always @(posedge sck1) if (ss_n1 === 1'b0) m1 = {m1[22:0], mosi1};

    int ss1_first = -1, ss1_last = -1;

    // Monitor: pops the expected frame whenever a DUT presents valid
    always @(negedge clk) begin
        if (valid0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_total++;
                $display("FAIL dut0 unexpected valid: got valid at cycle %0d, required none", cyc);
            end else begin
                e0 = q0.pop_front();
                check("dut0 data", 128'(data0), e0.data);
                check("dut0 valid cycle", 128'(cyc), 128'(e0.cyc));
            end
        end
        if (valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_total++;
                $display("FAIL dut1 unexpected valid: got valid at cycle %0d, required none", cyc);
            end else begin
                e1 = q1.pop_front();
                check("dut1 data", 128'(data1), e1.data);
                check("dut1 valid cycle", 128'(cyc), 128'(e1.cyc));
            end
        end
        if (valid2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_total++;
                $display("FAIL dut2 unexpected valid: got valid at cycle %0d, required none", cyc);
            end else begin
                e2 = q2.pop_front();
                check("dut2 data", 128'(data2), e2.data);
                check("dut2 valid cycle", 128'(cyc), 128'(e2.cyc));
            end
        end
        if (overrun0 === 1'b1) ovr0++;
        if (overrun1 === 1'b1) ovr1++;
        if (overrun2 === 1'b1) ovr2++;
        if (ss_n1 === 1'b0) begin
            if (ss1_first < 0) ss1_first = cyc;
            ss1_last = cyc;
        end
    end

    int t;
    int o;

    initial begin
        for (int i = 0; i < 15; i++) s0_bytes[i] = 8'(i);
        s1_bytes = '{8'h00, 8'h12, 8'h34};
        s2_bytes = '{8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};

        repeat (3) @(negedge clk);
        check("reset sck", 128'(sck0), 128'(1));
        check("reset mosi", 128'(mosi0), 128'(1));
        check("reset ss_n", 128'(ss_n0), 128'(1));
        check("reset busy", 128'(busy0), 128'(0));
        check("reset valid", 128'(valid0), 128'(0));
        check("reset overrun", 128'(overrun0), 128'(0));
        check("reset data", 128'(data0), 128'(0));
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);

        // Small burst: command byte BB then two dummy bytes, frame 1234 at T+99
        m1 = '0;
        ss1_first = -1;
        ss1_last = -1;
        t = cyc;
        q1.push_back('{128'h1234, t + 99});
        trig1 = 1'b1;
        @(negedge clk);
        trig1 = 1'b0;
        wait_cyc(t + 110);
        check("dut1 mosi bytes", 128'(m1), 128'hBBFFFF);
        check("dut1 ss_n first low", 128'(ss1_first), 128'(t + 1));
        check("dut1 ss_n last low", 128'(ss1_last), 128'(t + 98));

        // SCK_HALF=1: sck toggles every cycle from the first transfer cycle
        t = cyc;
        q2.push_back('{128'hC33C_A55A, t + 83});
        trig2 = 1'b1;
        @(negedge clk);
        trig2 = 1'b0;
        wait_cyc(t + 2);
        check("dut2 sck first xfer cycle", 128'(sck2), 128'(0));
        @(negedge clk);
        check("dut2 sck second xfer cycle", 128'(sck2), 128'(1));
        @(negedge clk);
        check("dut2 sck third xfer cycle", 128'(sck2), 128'(0));
        wait_cyc(t + 90);

        // Triggers every 10 cycles while busy, one in the valid cycle, one just after
        s1_bytes = '{8'h00, 8'h56, 8'h78};
        o = ovr1;
        t = cyc;
        q1.push_back('{128'h5678, t + 99});
        q1.push_back('{128'h5678, t + 199});
        trig1 = 1'b1;
        @(negedge clk);
        trig1 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            wait_cyc(t + 10 * i);
            trig1 = 1'b1;
            @(negedge clk);
            trig1 = 1'b0;
        end
        wait_cyc(t + 99);
        trig1 = 1'b1;
        @(negedge clk);
        trig1 = 1'b1;
        @(negedge clk);
        trig1 = 1'b0;
        wait_cyc(t + 210);
        check("dut1 overrun count", 128'(ovr1 - o), 128'(10));

        // en low: trigger ignored entirely
        o = ovr1;
        en1 = 1'b0;
        trig1 = 1'b1;
        @(negedge clk);
        trig1 = 1'b0;
        repeat (4) @(negedge clk);
        check("dut1 en=0 ss_n", 128'(ss_n1), 128'(1));
        check("dut1 en=0 busy", 128'(busy1), 128'(0));
        check("dut1 en=0 overrun", 128'(ovr1 - o), 128'(0));

        // en dropped mid-burst: burst still completes
        s1_bytes = '{8'h00, 8'h9A, 8'hBC};
        en1 = 1'b1;
        t = cyc;
        q1.push_back('{128'h9ABC, t + 99});
        trig1 = 1'b1;
        @(negedge clk);
        trig1 = 1'b0;
        wait_cyc(t + 30);
        en1 = 1'b0;
        wait_cyc(t + 40);
        check("dut1 busy after en drop", 128'(busy1), 128'(1));
        wait_cyc(t + 105);
        en1 = 1'b1;

        // Default configuration: 7 words from slave bytes 01..0E
        t = cyc;
        q0.push_back('{128'h0D0E_0B0C_090A_0708_0506_0304_0102, t + 6009});
        trig0 = 1'b1;
        @(negedge clk);
        trig0 = 1'b0;
        wait_cyc(t + 6020);

        // Reset in the middle of the transfer: partial frame dropped, no valid
        t = cyc;
        trig0 = 1'b1;
        @(negedge clk);
        trig0 = 1'b0;
        wait_cyc(t + 3000);
        check("dut0 mid-burst ss_n", 128'(ss_n0), 128'(0));
        rst0 = 1'b1;
        @(negedge clk);
        check("dut0 post-reset sck", 128'(sck0), 128'(1));
        check("dut0 post-reset ss_n", 128'(ss_n0), 128'(1));
        check("dut0 post-reset busy", 128'(busy0), 128'(0));
        check("dut0 post-reset mosi", 128'(mosi0), 128'(1));
        check("dut0 post-reset data", 128'(data0), 128'(0));
        rst0 = 1'b0;
        wait_cyc(t + 6100);

        check("dut0 pending frames", 128'(q0.size()), 128'(0));
        check("dut1 pending frames", 128'(q1.size()), 128'(0));
        check("dut2 pending frames", 128'(q2.size()), 128'(0));
        check("dut0 overrun count", 128'(ovr0), 128'(0));
        check("dut2 overrun count", 128'(ovr2), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
